// File: rtl/imm_gen_pipe_pkg.sv
// Shared types for the immediate generator: format encoding, RV32/64 base
// opcodes and the opcode-to-format decoder.
package rv_imm_pkg;

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_S   = 3'd1,
    FMT_B   = 3'd2,
    FMT_U   = 3'd3,
    FMT_J   = 3'd4,
    FMT_Z   = 3'd5,
    FMT_ILL = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  // SYSTEM splits on funct3[2]: the CSR*I forms carry a 5-bit uimm in rs1.
  function automatic imm_fmt_e decode_fmt(input logic [31:0] inst);
    imm_fmt_e f;
    case (inst[6:0])
      OP_IMM, LOAD, JALR: f = FMT_I;
      STORE:              f = FMT_S;
      BRANCH:             f = FMT_B;
      LUI, AUIPC:         f = FMT_U;
      JAL:                f = FMT_J;
      SYSTEM:             f = inst[14] ? FMT_Z : FMT_I;
      default:            f = FMT_ILL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between decode and the immediate stage, plus the
// stage's result and status outputs.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  import rv_imm_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      inst;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm;
  imm_fmt_e         fmt;
  logic             illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output in_valid, inst, flush, out_ready,
    input  in_ready, out_valid, imm, fmt, illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, inst, flush, out_ready,
    output in_ready, out_valid, imm, fmt, illegal, illegal_cnt
  );
endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate extraction: raw instruction -> extended immediate,
// format and illegal flag.
module imm_decode
  import rv_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_decode: XLEN must be 32 or 64, got %0d", XLEN);
  end

  // Every format fits in 32 bits; widening to XLEN is a single sign extend.
  logic signed [31:0] raw;

  always_comb begin
    fmt     = decode_fmt(inst);
    illegal = (fmt == FMT_ILL);
    raw     = '0;
    case (fmt)
      FMT_I:   raw = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                      inst[11:8], 1'b0};
      FMT_U:   raw = {inst[31:12], 12'b0};
      FMT_J:   raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                      inst[30:21], 1'b0};
      FMT_Z:   raw = {27'b0, inst[19:15]};
      default: raw = '0;
    endcase
    imm = XLEN'(raw);
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// One-register immediate stage with valid/ready, flush and a saturating
// count of accepted illegal-opcode entries.
module imm_gen_pipe
  import rv_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  imm_gen_pipe_if.slave bus
);

  logic [XLEN-1:0]  d_imm;
  imm_fmt_e         d_fmt;
  logic             d_illegal;

  logic             vld_q;
  logic [XLEN-1:0]  imm_q;
  imm_fmt_e         fmt_q;
  logic             ill_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .inst    (bus.inst),
    .imm     (d_imm),
    .fmt     (d_fmt),
    .illegal (d_illegal)
  );

  assign bus.in_ready = !vld_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Flush wins over both accept and drain; payload is left untouched so the
  // outputs only move when a real entry lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      imm_q <= '0;
      fmt_q <= FMT_ILL;
      ill_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (bus.flush) begin
        vld_q <= 1'b0;
      end else if (accept) begin
        vld_q <= 1'b1;
        imm_q <= d_imm;
        fmt_q <= d_fmt;
        ill_q <= d_illegal;
      end else if (bus.out_ready) begin
        vld_q <= 1'b0;
      end
      if (accept && !bus.flush && d_illegal && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.out_valid   = vld_q;
  assign bus.imm         = imm_q;
  assign bus.fmt         = fmt_q;
  assign bus.illegal     = ill_q;
  assign bus.illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: one XLEN=32/CNT_W=16 stage and one XLEN=64/CNT_W=2 stage.
module tb_imm_gen_pipe;
  import rv_imm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst32_n, rst64_n;

  imm_gen_pipe_if #(.XLEN(32), .CNT_W(16)) b32();
  imm_gen_pipe_if #(.XLEN(64), .CNT_W(2))  b64();

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) u32 (.clk(clk), .rst_n(rst32_n), .bus(b32.slave));
  imm_gen_pipe #(.XLEN(64), .CNT_W(2))  u64 (.clk(clk), .rst_n(rst64_n), .bus(b64.slave));

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (b32.out_valid && b32.out_ready) begin
      if (q32.size() == 0) begin
        chk("d32_unexpected_output", 64'(b32.imm), 64'hDEAD_0000_DEAD_0000);
      end else begin
        e32 = q32.pop_front();
        chk("d32_imm", 64'(b32.imm), e32.imm);
        chk("d32_fmt", 64'(b32.fmt), 64'(e32.fmt));
        chk("d32_illegal", 64'(b32.illegal), 64'(e32.ill));
      end
    end
  end

  always @(negedge clk) begin
    if (b64.out_valid && b64.out_ready) begin
      if (q64.size() == 0) begin
        chk("d64_unexpected_output", b64.imm, 64'hDEAD_0000_DEAD_0000);
      end else begin
        e64 = q64.pop_front();
        chk("d64_imm", b64.imm, e64.imm);
        chk("d64_fmt", 64'(b64.fmt), 64'(e64.fmt));
        chk("d64_illegal", 64'(b64.illegal), 64'(e64.ill));
      end
    end
  end

  // d=0 drives the 32-bit stage, d=1 the 64-bit stage.
  task automatic send(input bit d, input logic [31:0] i, input logic [63:0] ei,
                      input logic [2:0] ef, input bit el);
    exp_t e;
    int n = 0;
    bit rdy;
    e.imm = ei; e.fmt = ef; e.ill = el;
    if (d) begin b64.in_valid = 1'b1; b64.inst = i; end
    else   begin b32.in_valid = 1'b1; b32.inst = i; end
    do begin
      @(negedge clk);
      n++;
      rdy = d ? b64.in_ready : b32.in_ready;
    end while (!rdy && n < 50);
    if (!rdy) begin
      chk("send_timeout", 64'(rdy), 64'd1);
      b32.in_valid = 1'b0; b64.in_valid = 1'b0;
      return;
    end
    if (d) q64.push_back(e); else q32.push_back(e);
    @(posedge clk); #1;
    if (d) b64.in_valid = 1'b0; else b32.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    b32.in_valid = 0; b32.inst = '0; b32.flush = 0; b32.out_ready = 0;
    b64.in_valid = 0; b64.inst = '0; b64.flush = 0; b64.out_ready = 1;
    rst32_n = 1; rst64_n = 1;
    #1 rst32_n = 0; rst64_n = 0;
    #2;
    chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_imm", 64'(b32.imm), 64'd0);
    chk("rst_fmt", 64'(b32.fmt), 64'd7);
    chk("rst_illegal", 64'(b32.illegal), 64'd0);
    chk("rst_cnt", 64'(b32.illegal_cnt), 64'd0);
    chk("rst_in_ready", 64'(b32.in_ready), 64'd1);
    chk("rst64_fmt", 64'(b64.fmt), 64'd7);
    @(posedge clk); #1;
    rst32_n = 1; rst64_n = 1; b32.out_ready = 1;

    // 32-bit directed vectors, back-to-back
    send(0, 32'hFFF00093, 64'hFFFFFFFF, 3'd0, 0);  // addi x1,x0,-1
    send(0, 32'hFE000EE3, 64'hFFFFFFFC, 3'd2, 0);  // beq -4
    send(0, 32'h0010006F, 64'h00000800, 3'd4, 0);  // jal +2048
    send(0, 32'h300FD073, 64'h0000001F, 3'd5, 0);  // csrrwi uimm=31
    send(0, 32'hFE20AC23, 64'hFFFFFFF8, 3'd1, 0);  // sw x2,-8(x1)
    send(0, 32'h12345097, 64'h12345000, 3'd3, 0);  // auipc
    send(0, 32'h00000073, 64'h00000000, 3'd0, 0);  // ecall -> I
    send(0, 32'h00412083, 64'h00000004, 3'd0, 0);  // lw x1,4(x2)
    send(0, 32'h0000007F, 64'h00000000, 3'd7, 1);  // illegal opcode
    idle(2);
    chk("cnt_after_illegal", 64'(b32.illegal_cnt), 64'd1);

    // flush in the accept cycle: entry dropped, not counted
    b32.in_valid = 1; b32.inst = 32'h0000007F; b32.flush = 1;
    @(negedge clk);
    chk("flush_in_ready", 64'(b32.in_ready), 64'd1);
    @(posedge clk); #1;
    b32.in_valid = 0; b32.flush = 0;
    chk("flush_out_valid", 64'(b32.out_valid), 64'd0);
    chk("flush_cnt", 64'(b32.illegal_cnt), 64'd1);

    // flush of a stalled held entry
    b32.out_ready = 0;
    send(0, 32'hFFF00093, 64'hFFFFFFFF, 3'd0, 0);
    chk("held_valid", 64'(b32.out_valid), 64'd1);
    b32.flush = 1;
    @(posedge clk); #1;
    b32.flush = 0;
    chk("flush_held_valid", 64'(b32.out_valid), 64'd0);
    void'(q32.pop_back());
    b32.out_ready = 1;
    idle(1);

    // backpressure: addi held while a LUI waits
    b32.out_ready = 0;
    send(0, 32'hFFF00093, 64'hFFFFFFFF, 3'd0, 0);
    b32.in_valid = 1; b32.inst = 32'h123450B7;
    repeat (2) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(b32.in_ready), 64'd0);
      chk("bp_imm_hold", 64'(b32.imm), 64'hFFFFFFFF);
      chk("bp_out_valid", 64'(b32.out_valid), 64'd1);
    end
    @(posedge clk); #1;
    b32.out_ready = 1;
    e32.imm = 64'h12345000; e32.fmt = 3'd3; e32.ill = 0;
    q32.push_back(e32);
    @(posedge clk); #1;
    b32.in_valid = 0;
    idle(3);
    chk("bp_drained", 64'(b32.out_valid), 64'd0);

    // 64-bit stage
    send(1, 32'h123450B7, 64'h0000000012345000, 3'd3, 0);
    send(1, 32'h800000B7, 64'hFFFFFFFF80000000, 3'd3, 0);
    send(1, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd0, 0);
    send(1, 32'h0010006F, 64'h0000000000000800, 3'd4, 0);
    for (int k = 0; k < 5; k++)
      send(1, 32'h0000007F, 64'h0, 3'd7, 1);
    idle(2);
    chk("cnt_saturate", 64'(b64.illegal_cnt), 64'd3);

    // asynchronous reset with a held entry
    b64.out_ready = 0;
    send(1, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd0, 0);
    chk("pre_rst_valid", 64'(b64.out_valid), 64'd1);
    #2 rst64_n = 0;
    #1;
    chk("async_rst_valid", 64'(b64.out_valid), 64'd0);
    chk("async_rst_cnt", 64'(b64.illegal_cnt), 64'd0);
    chk("async_rst_imm", b64.imm, 64'd0);
    q64.delete();
    @(posedge clk); #1;
    rst64_n = 1; b64.out_ready = 1;
    send(1, 32'h00412083, 64'h4, 3'd0, 0);
    idle(2);
    chk("post_rst_cnt", 64'(b64.illegal_cnt), 64'd0);

    chk("q32_empty", 64'(q32.size()), 64'd0);
    chk("q64_empty", 64'(q64.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined immediate generator for the RISC-V core. It takes a raw 32-bit instruction word and decodes the immediate format itself from the opcode, so no external select is needed. It produces an XLEN-wide extended immediate (32 or 64) through one registered stage with a valid/ready handshake. It sits between fetch/decode and execute, and supports stall, flush and a saturating illegal-format counter.

## Interface
Parameters:
- XLEN, 32: output immediate width; legal values are 32 and 64 only.
- CNT_W, 16: width of the illegal-format counter.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  inst is valid this cycle
- in_ready  output  1  stage can accept inst
- inst  input  32  raw instruction word
- flush  input  1  drop held and incoming entry
- out_valid  output  1  imm/fmt valid
- out_ready  input  1  consumer accepts
- imm  output  XLEN  extended immediate
- fmt  output  3  imm_fmt_e of the held entry
- illegal  output  1  held entry had an unrecognised opcode
- illegal_cnt  output  CNT_W  saturating count of accepted illegal entries

## Operation
- Format decode on inst[6:0]:
  - 0010011, 0000011, 1100111 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - 1110011 with inst[14]=1 → Z; with inst[14]=0 → I
  - any other opcode → ILL
- Immediate construction, where sext means replicate inst[31] up to XLEN:
  - I: sext(inst[31:20])
  - S: sext({inst[31:25], inst[11:7]})
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})
  - U: sext({inst[31:12], 12'b0}). U is sign-extended to XLEN, as RV64 requires.
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})
  - Z: zero-extended inst[19:15]
  - ILL: imm = 0 and illegal = 1
- Handshake (single pipeline register):
  - in_ready = !out_valid || out_ready.
  - An accept occurs when in_valid && in_ready. On accept, the register loads imm/fmt/illegal and out_valid is set.
  - If out_valid && out_ready with no accept, out_valid clears.
- While out_valid && !out_ready, imm/fmt/illegal are held stable.
- illegal_cnt increments by 1 on each accept of an ILL entry and saturates at all-ones. It is never cleared except by reset.
- flush:
  - Next cycle out_valid = 0.
  - Any same-cycle accept is discarded and does not count toward illegal_cnt.
  - in_ready is unaffected by flush.

## Timing
- Latency is 1 cycle: an inst accepted at edge N appears on imm at edge N and remains valid until consumed.
- Throughput is 1 per cycle while out_ready = 1. Simultaneous consume and accept replaces the entry with no bubble.
- Reset values: out_valid = 0, imm = 0, fmt = ILL encoding, illegal = 0, illegal_cnt = 0. in_ready is 1 out of reset.
- Reset asserted mid-transfer drops the held entry immediately (asynchronous). The first accept is possible on the first clk edge after rst_n rises.
- The registered outputs are glitch-free. in_ready is combinational from out_ready.

## Structure
- Package rv_imm_pkg holds:
  - imm_fmt_e enum, 3 bits: I=0, S=1, B=2, U=3, J=4, Z=5, ILL=7.
  - Opcode localparams: OP_IMM, LOAD, JALR, STORE, BRANCH, LUI, AUIPC, JAL, SYSTEM.
- Sub-module imm_decode<XLEN> is purely combinational: inst → {imm, fmt, illegal}. imm_gen_pipe wraps it with the handshake register and the counter.
- An XLEN value other than 32 or 64 triggers an elaboration-time error.

## Test plan
- XLEN=32, inst=0xFFF00093 (addi x1, x0, -1), out_ready=1 → next cycle imm=0xFFFFFFFF, fmt=I, illegal=0.
- inst=0xFE000EE3 (beq -4) → imm=0xFFFFFFFC, fmt=B.
- inst=0x0010006F → imm=0x00000800, fmt=J.
- inst=0x300FD073 (csrrwi) → imm=0x0000001F, fmt=Z.
- XLEN=64: inst=0x123450B7 → imm=0x0000000012345000; inst=0x800000B7 → imm=0xFFFFFFFF80000000.
- Backpressure:
  - Send the addi, then a LUI with out_ready=0 for 2 cycles. in_ready=0 and imm stays 0xFFFFFFFF.
  - Raise out_ready: addi is consumed, then LUI follows the next cycle with no loss or duplication.
- Illegal and flush:
  - inst=0x0000007F accepted → illegal=1, imm=0, illegal_cnt=1.
  - Same inst with flush=1 in the accept cycle → out_valid=0 next cycle, illegal_cnt remains 1.
  - CNT_W=2 with 5 illegal accepts → illegal_cnt saturates at 3.
  - rst_n pulsed low with out_valid=1 → out_valid=0 and illegal_cnt=0 immediately.
